// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution datapath: window indexing,
// counter widths and the legal-kernel check.
package conv_pkg;

  localparam int KERNEL_MAX = 7;

  function automatic logic kernel_legal(input int k);
    return (k >= 1) && (k <= KERNEL_MAX) && ((k % 2) == 1);
  endfunction

  // Flattened window element index; r=0 is the oldest row, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Counter width, never below one bit so degenerate sizes still elaborate.
  function automatic int cw(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay: circular buffer addressed by column, read before write.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int N     = 8,
  parameter int AW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [N-1:0]  din_i,
  output logic [N-1:0]  dout_o
);

  logic [N-1:0] mem_q [DEPTH];

  // The read returns the pixel written one row earlier at this column.
  assign dout_o = mem_q[addr_i];

  // Storage write; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to KERNEL x KERNEL sliding-window generator ("valid" convolution,
// no padding) feeding the convolution calculator.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [KERNEL*KERNEL*N-1:0] data2conv,
  output logic                       en_out,
  output logic [cw(IMG_H)-1:0]       win_row,
  output logic [cw(IMG_W)-1:0]       win_col,
  output logic                       frame_done
);

  localparam int CW   = cw(IMG_W);
  localparam int RW   = cw(IMG_H);
  localparam int LB_N = (KERNEL > 1) ? KERNEL - 1 : 1;
  localparam int FW   = KERNEL * KERNEL * N;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_OFS  = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_OFS  = RW'(KERNEL - 1);

  logic [CW-1:0] col_q, col_d, pos_col_s;
  logic [RW-1:0] row_q, row_d, pos_row_s;
  logic [N-1:0]  win_q [KERNEL][KERNEL];
  logic [N-1:0]  win_d [KERNEL][KERNEL];
  logic [N-1:0]  lb_dout_s [LB_N];
  logic [FW-1:0] flat_s, data_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic          col_ok_s, row_ok_s, emit_s, lb_wr_s;
  logic          en_q, done_q;

  assign data2conv  = data_q;
  assign en_out     = en_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = done_q;

  // Position of the pixel being accepted (sof forces it to the origin) and counter advance.
  always_comb begin
    pos_col_s = sof ? {CW{1'b0}} : col_q;
    pos_row_s = sof ? {RW{1'b0}} : row_q;
    col_d     = col_q;
    row_d     = row_q;
    if (pix_valid) begin
      if (pos_col_s == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (pos_row_s == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = pos_row_s + RW'(1'b1);
        end
      end else begin
        col_d = pos_col_s + CW'(1'b1);
        row_d = pos_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Only full windows inside the current row and frame are emitted.
  generate
    if (KERNEL == 1) begin : g_ok_k1
      assign col_ok_s = 1'b1;
      assign row_ok_s = 1'b1;
    end else begin : g_ok_kn
      assign col_ok_s = (pos_col_s >= COL_OFS);
      assign row_ok_s = (pos_row_s >= ROW_OFS);
    end
  endgenerate

  assign emit_s  = pix_valid & col_ok_s & row_ok_s;
  assign lb_wr_s = pix_valid & ~rst;

  // Cascaded row delays: buffer k yields the pixel k+1 rows above the current one.
  generate
    if (KERNEL > 1) begin : g_lb
      for (genvar k = 0; k < KERNEL - 1; k++) begin : g_row
        logic [N-1:0] din_s;
        if (k == 0) begin : g_first
          assign din_s = pix_in;
        end else begin : g_next
          assign din_s = lb_dout_s[k-1];
        end
        conv_line_buffer #(
          .DEPTH (IMG_W),
          .N     (N),
          .AW    (CW)
        ) u_lb (
          .clk     (clk),
          .wr_en_i (lb_wr_s),
          .addr_i  (pos_col_s),
          .din_i   (din_s),
          .dout_o  (lb_dout_s[k])
        );
      end
    end else begin : g_no_lb
      assign lb_dout_s[0] = {N{1'b0}};
    end
  endgenerate

  // Window shift: drop the oldest column, append line-buffer taps plus the new pixel.
  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < KERNEL - 1; r++) begin
        win_d[r][KERNEL-1] = lb_dout_s[KERNEL-2-r];
      end
      win_d[KERNEL-1][KERNEL-1] = pix_in;
    end else begin
      win_d = win_q;
    end
  end

  // Flatten the next window in calculator order.
  always_comb begin
    flat_s = {FW{1'b0}};
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        flat_s[win_idx(r, c, KERNEL)*N +: N] = win_d[r][c];
      end
    end
  end

  // State and registered outputs; data and coordinates only move on an emitted window.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= {CW{1'b0}};
      row_q     <= {RW{1'b0}};
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= {FW{1'b0}};
      win_row_q <= {RW{1'b0}};
      win_col_q <= {CW{1'b0}};
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win_q[r][c] <= {N{1'b0}};
        end
      end
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      en_q   <= emit_s;
      done_q <= emit_s & (pos_col_s == COL_LAST) & (pos_row_s == ROW_LAST);
      if (emit_s) begin
        data_q    <= flat_s;
        win_row_q <= pos_row_s - ROW_OFS;
        win_col_q <= pos_col_s - COL_OFS;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: KERNEL=3 on 5x5, KERNEL=1 on 4x4, KERNEL=7 on 8x8.
module tb_conv_window_gen;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // KERNEL=3, 5x5
  logic        rst3, pix_valid3, sof3, en_out3, frame_done3;
  logic [7:0]  pix_in3;
  logic [71:0] data2conv3;
  logic [cw(5)-1:0] win_row3, win_col3;
  // KERNEL=1, 4x4
  logic        rst1, pix_valid1, sof1, en_out1, frame_done1;
  logic [7:0]  pix_in1, data2conv1;
  logic [cw(4)-1:0] win_row1, win_col1;
  // KERNEL=7, 8x8
  logic        rst7, pix_valid7, sof7, en_out7, frame_done7;
  logic [7:0]  pix_in7;
  logic [391:0] data2conv7;
  logic [cw(8)-1:0] win_row7, win_col7;

  conv_window_gen #(.KERNEL(3), .N(8), .IMG_W(5), .IMG_H(5)) u_dut3 (
    .clk(clk), .rst(rst3), .pix_in(pix_in3), .pix_valid(pix_valid3), .sof(sof3),
    .data2conv(data2conv3), .en_out(en_out3), .win_row(win_row3), .win_col(win_col3),
    .frame_done(frame_done3));

  conv_window_gen #(.KERNEL(1), .N(8), .IMG_W(4), .IMG_H(4)) u_dut1 (
    .clk(clk), .rst(rst1), .pix_in(pix_in1), .pix_valid(pix_valid1), .sof(sof1),
    .data2conv(data2conv1), .en_out(en_out1), .win_row(win_row1), .win_col(win_col1),
    .frame_done(frame_done1));

  conv_window_gen #(.KERNEL(7), .N(8), .IMG_W(8), .IMG_H(8)) u_dut7 (
    .clk(clk), .rst(rst7), .pix_in(pix_in7), .pix_valid(pix_valid7), .sof(sof7),
    .data2conv(data2conv7), .en_out(en_out7), .win_row(win_row7), .win_col(win_col7),
    .frame_done(frame_done7));

  typedef struct {
    int          r;
    int          c;
    logic [71:0] d;
    logic        done;
  } ev_t;

  ev_t q3[$];
  ev_t q1[$];
  ev_t q7[$];
  ev_t m3, m1, m7;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every strobe away from the active edge.
  always @(negedge clk) begin
    if (en_out3) begin
      m3.r = int'(win_row3); m3.c = int'(win_col3); m3.d = data2conv3; m3.done = frame_done3;
      q3.push_back(m3);
    end
    if (en_out1) begin
      m1.r = int'(win_row1); m1.c = int'(win_col1); m1.d = 72'(data2conv1); m1.done = frame_done1;
      q1.push_back(m1);
    end
    if (en_out7) begin
      m7.r = int'(win_row7); m7.c = int'(win_col7);
      m7.d = 72'({data2conv7[48*8 +: 8], data2conv7[7:0]}); m7.done = frame_done7;
      q7.push_back(m7);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Feed raster pixels first..first+cnt-1 of a 5x5 frame; optional idle gap with a stray sof.
  task automatic feed3(input int off, input int first, input int cnt, input bit gap, input bit sof_first);
    logic [71:0] held;
    for (int i = 0; i < cnt; i++) begin
      int p;
      p = first + i;
      pix_in3    = 8'(off + (p / 5) * 16 + (p % 5));
      pix_valid3 = 1'b1;
      sof3       = sof_first && (i == 0);
      @(posedge clk); #1;
      pix_valid3 = 1'b0;
      sof3       = 1'b0;
      if (gap) begin
        held = data2conv3;
        sof3 = 1'b1;
        @(posedge clk); #1;
        sof3 = 1'b0;
        check_val("idle_en", 72'(en_out3), 72'(1'b0));
        check_val("idle_data", data2conv3, held);
      end
    end
  endtask

  task automatic verify3(input int off, input int nwin);
    ev_t e;
    logic [71:0] exp_d;
    int wr, wc;
    for (int w = 0; w < nwin; w++) begin
      if (q3.size() == 0) return;
      e  = q3.pop_front();
      wr = w / 3;
      wc = w % 3;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          exp_d[(r*3+c)*8 +: 8] = 8'(off + (wr + r) * 16 + wc + c);
        end
      end
      check_val("k3_row", 72'(e.r), 72'(wr));
      check_val("k3_col", 72'(e.c), 72'(wc));
      check_val("k3_data", e.d, exp_d);
      check_val("k3_done", 72'(e.done), 72'(wr == 2 && wc == 2));
    end
  endtask

  initial begin
    ev_t e;
    rst3 = 1'b1; rst1 = 1'b1; rst7 = 1'b1;
    pix_valid3 = 1'b0; pix_valid1 = 1'b0; pix_valid7 = 1'b0;
    sof3 = 1'b0; sof1 = 1'b0; sof7 = 1'b0;
    pix_in3 = 8'h00; pix_in1 = 8'h00; pix_in7 = 8'h00;
    idle(3);
    check_val("rst3_en", 72'(en_out3), 72'(1'b0));
    check_val("rst3_done", 72'(frame_done3), 72'(1'b0));
    check_val("rst3_data", data2conv3, 72'h0);
    check_val("rst3_row", 72'(win_row3), 72'h0);
    check_val("rst3_col", 72'(win_col3), 72'h0);
    check_val("rst1_data", 72'(data2conv1), 72'h0);
    check_val("rst7_data", 72'(|data2conv7), 72'h0);
    rst3 = 1'b0; rst1 = 1'b0; rst7 = 1'b0;
    idle(1);

    // Continuous frame
    q3.delete();
    feed3(0, 0, 25, 1'b0, 1'b1);
    idle(3);
    check_val("t1_count", 72'(q3.size()), 72'd9);
    verify3(0, 9);

    // Alternating valid, stray sof on idle cycles
    q3.delete();
    feed3(0, 0, 25, 1'b1, 1'b1);
    idle(3);
    check_val("t2_count", 72'(q3.size()), 72'd9);
    verify3(0, 9);

    // Two back-to-back frames
    q3.delete();
    feed3(0, 0, 25, 1'b0, 1'b1);
    feed3(8'h80, 0, 25, 1'b0, 1'b1);
    idle(3);
    check_val("t3_count", 72'(q3.size()), 72'd18);
    verify3(0, 9);
    verify3(8'h80, 9);

    // Reset in place of pixel (col 3, row 2)
    q3.delete();
    feed3(0, 0, 13, 1'b0, 1'b1);
    rst3 = 1'b1;
    idle(1);
    rst3 = 1'b0;
    check_val("t4r_en", 72'(en_out3), 72'(1'b0));
    check_val("t4r_data", data2conv3, 72'h0);
    feed3(8'h40, 0, 25, 1'b0, 1'b0);
    idle(3);
    check_val("t4r_count", 72'(q3.size()), 72'd10);
    verify3(0, 1);
    verify3(8'h40, 9);

    // sof in place of pixel (col 3, row 2)
    q3.delete();
    feed3(0, 0, 13, 1'b0, 1'b1);
    feed3(8'h40, 0, 25, 1'b0, 1'b1);
    idle(3);
    check_val("t4s_count", 72'(q3.size()), 72'd10);
    verify3(0, 1);
    verify3(8'h40, 9);

    // KERNEL=1: every pixel is a window
    q1.delete();
    for (int p = 0; p < 16; p++) begin
      pix_in1    = 8'((p / 4) * 16 + (p % 4));
      pix_valid1 = 1'b1;
      sof1       = (p == 0);
      @(posedge clk); #1;
    end
    pix_valid1 = 1'b0;
    sof1       = 1'b0;
    idle(3);
    check_val("k1_count", 72'(q1.size()), 72'd16);
    for (int p = 0; p < 16; p++) begin
      if (q1.size() == 0) break;
      e = q1.pop_front();
      check_val("k1_data", e.d, 72'((p / 4) * 16 + (p % 4)));
      check_val("k1_row", 72'(e.r), 72'(p / 4));
      check_val("k1_col", 72'(e.c), 72'(p % 4));
      check_val("k1_done", 72'(e.done), 72'(p == 15));
    end

    // KERNEL=7 on 8x8: four windows
    q7.delete();
    for (int p = 0; p < 64; p++) begin
      pix_in7    = 8'((p / 8) * 16 + (p % 8));
      pix_valid7 = 1'b1;
      sof7       = (p == 0);
      @(posedge clk); #1;
    end
    pix_valid7 = 1'b0;
    sof7       = 1'b0;
    idle(3);
    check_val("k7_count", 72'(q7.size()), 72'd4);
    for (int w = 0; w < 4; w++) begin
      if (q7.size() == 0) break;
      e = q7.pop_front();
      check_val("k7_row", 72'(e.r), 72'(w / 2));
      check_val("k7_col", 72'(e.c), 72'(w % 2));
      check_val("k7_e0", 72'(e.d[7:0]), 72'((w / 2) * 16 + (w % 2)));
      check_val("k7_e48", 72'(e.d[15:8]), 72'((w / 2 + 6) * 16 + (w % 2) + 6));
      check_val("k7_done", 72'(e.done), 72'(w == 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
